// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/sequencing controller.
// Provides the FSM state enum, the x0 register constant and a one-hot decoder.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    function automatic logic [31:0] onehot(input logic [4:0] addr);
        onehot = 32'd1 << addr;
    endfunction

endpackage

// File: rtl/pipeline_scoreboard.sv
// 32-entry in-flight register write scoreboard.
// Ports: clk_i, rstn_i (async active-low), set_i / clr_i one-hot update masks,
// pending_o (bit n = write to xn in flight; bit 0 is always 0).
module pipeline_scoreboard
    import pipeline_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] set_i,
    input  logic [31:0] clr_i,
    output logic [31:0] pending_o
);

    logic [31:0] pending_q;
    logic [31:0] pending_d;

    // x0 is hardwired zero, so its bit is masked regardless of the inputs.
    always_comb begin
        pending_d = ((pending_q & ~clr_i) | set_i) & ~onehot(REG_X0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller: scoreboard interlock, redirect flush,
// memory-wait freeze and watchdog. Optional macro: PIPELINE_CTRL_WB_BYPASS_EN.
// Ports: clk_i, rstn_i, ID source/dest info, ex_bnj_taken_i, mem_req_i/mem_ack_i,
// WB write info; stall/flush controls, pending_o, sticky mem_timeout_o.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_write_rd_i,
    input  logic        ex_bnj_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    input  logic        wb_write_rd_i,
    input  logic [4:0]  wb_rd_addr_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_flush_o,
    output logic [31:0] pending_o,
    output logic        mem_timeout_o
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic          mem_wait;
    logic          redirect;
    logic          raw;
    logic          hazard;
    logic          issue;
    logic [31:0]   pending;
    logic [31:0]   pend_eff;
    logic [31:0]   set_vec;
    logic [31:0]   clr_vec;

    // Hazard terms are qualified by rstn_i so every control is 0 in reset.
    assign mem_wait = rstn_i & mem_req_i & ~mem_ack_i;
    assign redirect = rstn_i & ex_bnj_taken_i & ~mem_wait;

    assign clr_vec = (wb_write_rd_i && wb_rd_addr_i != REG_X0)
                   ? onehot(wb_rd_addr_i) : '0;

`ifdef PIPELINE_CTRL_WB_BYPASS_EN
    // Register file writes before it reads, so the WB target is already safe.
    assign pend_eff = pending & ~clr_vec;
`else
    assign pend_eff = pending;
`endif

    assign raw = id_valid_i & (
          (id_uses_rs1_i & (id_rs1_addr_i != REG_X0) & pend_eff[id_rs1_addr_i])
        | (id_uses_rs2_i & (id_rs2_addr_i != REG_X0) & pend_eff[id_rs2_addr_i])
        | (id_write_rd_i & (id_rd_addr_i  != REG_X0) & pend_eff[id_rd_addr_i]));

    assign hazard = rstn_i & raw & ~mem_wait & ~redirect;

    assign issue = id_valid_i & id_write_rd_i & (id_rd_addr_i != REG_X0)
                 & ~mem_wait & ~redirect & ~hazard;

    assign set_vec = issue ? onehot(id_rd_addr_i) : '0;

    pipeline_scoreboard u_sb (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .set_i     (set_vec),
        .clr_i     (clr_vec),
        .pending_o (pending)
    );

    assign pc_stall_o     = mem_wait | hazard;
    assign if_id_stall_o  = mem_wait | hazard;
    assign if_id_flush_o  = redirect;
    assign id_ex_stall_o  = mem_wait;
    assign ex_mem_stall_o = mem_wait;
    assign id_ex_flush_o  = redirect | hazard;
    assign mem_wb_flush_o = mem_wait;
    assign pending_o      = pending;
    assign mem_timeout_o  = timeout_q;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (mem_wait)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_wait) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Watchdog: the first wait cycle is counted on entry, so the counter
    // equals the number of consecutive wait cycles; it saturates at the limit.
    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait) cnt_d = CNT_ONE;
            end
            MEM_WAIT: begin
                if (mem_wait)
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            end
            default: cnt_d = '0;
        endcase
        if (cnt_d == CNT_MAX) timeout_d = 1'b1;
    end

endmodule
